// File: rtl/sram_burst_reader_pkg.sv
// Shared types for the SPRAM burst reader: controller states and FIFO sizing helper.
package sram_burst_reader_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, STALL} state_e;

   // Pointer width of the prefetch FIFO; depth is a power of two, at least 2.
   function automatic int fifo_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/sram_burst_reader_fifo.sv
// Prefetch FIFO: registered head (no fall-through), push+pop when full both succeed.
module sram_burst_reader_fifo
   import sram_burst_reader_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = fifo_aw(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      level_q;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == FULL_LVL);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = mem_q[rd_q];
   assign level_o = level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         if (do_push & ~do_pop)      level_q <= level_q + (AW+1)'(1);
         else if (do_pop & ~do_push) level_q <= level_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/sram_burst_reader.sv
// SPRAM burst read client: one outstanding read on channel 1, words buffered in a prefetch FIFO.
// SRAM_BURST_READER_LOOP_EN adds loop/stop inputs for repeating bursts.
module sram_burst_reader
   import sram_burst_reader_pkg::*;
#(
   parameter int ADDRESS_BUS_WIDTH = 12,
   parameter int DATA_BUS_WIDTH    = 16,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDRESS_BUS_WIDTH-1:0]  base_address,
   input  logic [ADDRESS_BUS_WIDTH-1:0]  length,
`ifdef SRAM_BURST_READER_LOOP_EN
   input  logic                          loop,
   input  logic                          stop,
`endif
   output logic                          busy,
   output logic                          done,
   output logic [ADDRESS_BUS_WIDTH-1:0]  read_address,
   output logic                          read_strobe,
   input  logic                          read_finished_strobe,
   input  logic [DATA_BUS_WIDTH-1:0]     read_data,
   output logic [DATA_BUS_WIDTH-1:0]     out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = ADDRESS_BUS_WIDTH;
   localparam logic [AW-1:0] ONE = AW'(1);

   state_e        state_q;
   logic [AW-1:0] addr_q, remaining_q;
   logic          pending_q, busy_q, done_q;
   logic          push, pop, fifo_full, fifo_empty, room, stop_hit;

`ifdef SRAM_BURST_READER_LOOP_EN
   logic [AW-1:0] base_q, length_q;
   logic          loop_q, stop_q;
   assign stop_hit = stop | stop_q;
`else
   assign stop_hit = 1'b0;
`endif

   // A finish pulse seen while nothing is pending is not ours and is dropped.
   assign push         = pending_q & read_finished_strobe;
   assign read_strobe  = pending_q & ~read_finished_strobe;
   assign read_address = addr_q;
   assign pop          = ~fifo_empty & out_ready;
   assign room         = ~fifo_full | pop;
   assign busy         = busy_q;
   assign done         = done_q;
   assign out_valid    = ~fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         pending_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SRAM_BURST_READER_LOOP_EN
         base_q      <= '0;
         length_q    <= '0;
         loop_q      <= 1'b0;
         stop_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef SRAM_BURST_READER_LOOP_EN
         if (state_q == IDLE) stop_q <= 1'b0;
         else if (stop)       stop_q <= 1'b1;
`endif
         unique case (state_q)
            IDLE: if (start) begin
               if (length != '0) begin
                  addr_q      <= base_address;
                  remaining_q <= length;
                  busy_q      <= 1'b1;
                  state_q     <= REQ;
`ifdef SRAM_BURST_READER_LOOP_EN
                  base_q      <= base_address;
                  length_q    <= length;
                  loop_q      <= loop;
`endif
               end else begin
                  done_q <= 1'b1;
               end
            end
            // Only raise a request when its word is guaranteed a slot.
            REQ: if (stop_hit) begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end else if (room) begin
               pending_q <= 1'b1;
               state_q   <= WAIT;
            end else begin
               state_q <= STALL;
            end
            WAIT: if (push) begin
               pending_q   <= 1'b0;
               addr_q      <= addr_q + ONE;
               remaining_q <= remaining_q - ONE;
               if (stop_hit) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (remaining_q == ONE) begin
                  done_q <= 1'b1;
`ifdef SRAM_BURST_READER_LOOP_EN
                  if (loop_q) begin
                     addr_q      <= base_q;
                     remaining_q <= length_q;
                     state_q     <= REQ;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
`else
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
`endif
               end else begin
                  state_q <= REQ;
               end
            end
            STALL: if (stop_hit) begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end else if (room) begin
               state_q <= REQ;
            end
         endcase
      end
   end

   sram_burst_reader_fifo #(
      .WIDTH (DATA_BUS_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (read_data),
      .pop_i       (pop),
      .head_o      (out_data),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .level_o     (fifo_level)
   );

endmodule

// File: tb/tb_sram_burst_reader.sv
// Bench for sram_burst_reader: SPRAM arbiter model with one-cycle read latency and optional
// write-priority stalls; expected streams come from a flat memory array and address arithmetic.
module tb_sram_burst_reader;

   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst, start, out_ready;
   logic [AW-1:0] base_address, length;
   logic          busy, done, read_strobe, out_valid;
   logic [AW-1:0] read_address;
   logic          read_finished_strobe;
   logic [DW-1:0] read_data, out_data;
   logic [LW-1:0] fifo_level;
`ifdef SRAM_BURST_READER_LOOP_EN
   logic          loop = 1'b0, stop = 1'b0;
`endif

   always #5 clk = ~clk;

   sram_burst_reader #(
      .ADDRESS_BUS_WIDTH (AW),
      .DATA_BUS_WIDTH    (DW),
      .FIFO_DEPTH        (DEPTH)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .base_address         (base_address),
      .length               (length),
`ifdef SRAM_BURST_READER_LOOP_EN
      .loop                 (loop),
      .stop                 (stop),
`endif
      .busy                 (busy),
      .done                 (done),
      .read_address         (read_address),
      .read_strobe          (read_strobe),
      .read_finished_strobe (read_finished_strobe),
      .read_data            (read_data),
      .out_data             (out_data),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .fifo_level           (fifo_level)
   );

   int compared = 0, mismatched = 0;
   int cyc = 0, start_cyc = 0, first_valid_cyc = -1;
   int done_cnt = 0, busy_seen = 0;
   logic [DW-1:0] sram [1 << AW];
   logic [AW-1:0] acc_addr [$];
   logic [DW-1:0] got [$];
   logic          contend = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Arbiter model plus stream/done monitors; all sampling on the falling edge.
   initial begin
      logic          accepted, prev_strobe, s_strobe, s_valid;
      logic [AW-1:0] acc_a, prev_addr, s_addr;
      accepted = 1'b0; prev_strobe = 1'b0; prev_addr = '0; acc_a = '0;
      read_finished_strobe = 1'b0;
      read_data = '0;
      forever begin
         @(negedge clk);
         s_strobe = read_strobe;
         s_addr   = read_address;
         s_valid  = out_valid;
         if (s_valid && out_ready) got.push_back(out_data);
         if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) done_cnt++;
         if (busy) busy_seen++;
         if (s_strobe && prev_strobe) begin
            compared++;
            if (s_addr !== prev_addr) begin
               mismatched++;
               $display("FAIL addr_stable: got %h, required %h", s_addr, prev_addr);
            end
         end
         if (read_finished_strobe) begin
            read_finished_strobe = 1'b0;
         end else if (accepted) begin
            read_finished_strobe = 1'b1;
            read_data = sram[acc_a];
            accepted = 1'b0;
         end else if (s_strobe && !(contend && $urandom_range(0, 2) != 0)) begin
            accepted = 1'b1;
            acc_a = s_addr;
            acc_addr.push_back(s_addr);
         end
         prev_strobe = s_strobe;
         prev_addr   = s_addr;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
      base_address = b;
      length = l;
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      compared += 6;
      if (busy !== 1'b0)        begin mismatched++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (done !== 1'b0)        begin mismatched++; $display("FAIL reset_done: got %b, required 0", done); end
      if (read_strobe !== 1'b0) begin mismatched++; $display("FAIL reset_strobe: got %b, required 0", read_strobe); end
      if (read_address !== '0)  begin mismatched++; $display("FAIL reset_addr: got %h, required 0", read_address); end
      if (out_valid !== 1'b0)   begin mismatched++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      if (fifo_level !== '0)    begin mismatched++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
      rst = 1'b0;
      tick();
   endtask

   // Directed and random bursts: basic, address wrap, random backpressure, arbiter stalls.
   task automatic test_bursts();
      logic [AW-1:0] tb_base [10];
      logic [AW-1:0] tb_len  [10];
      bit            tb_rnd  [10];
      bit            tb_cont [10];
      sram[12'h010] = 16'hA0A0; sram[12'h011] = 16'hB1B1; sram[12'h012] = 16'hC2C2;
      tb_base[0] = 12'h010; tb_len[0] = 12'd3; tb_rnd[0] = 0; tb_cont[0] = 0;
      tb_base[1] = 12'hFFE; tb_len[1] = 12'd4; tb_rnd[1] = 0; tb_cont[1] = 0;
      for (int k = 2; k < 10; k++) begin
         tb_base[k] = AW'($urandom);
         tb_len[k]  = AW'($urandom_range(1, 10));
         tb_rnd[k]  = (k >= 4);
         tb_cont[k] = (k >= 6);
      end
      for (int k = 0; k < 10; k++) begin
         int n;
         logic [AW-1:0] ea;
         acc_addr.delete(); got.delete();
         done_cnt = 0; first_valid_cyc = -1;
         contend = tb_cont[k];
         out_ready = tb_rnd[k] ? 1'($urandom_range(0, 1)) : 1'b1;
         pulse_start(tb_base[k], tb_len[k]);
         n = 0;
         while ((got.size() < int'(tb_len[k]) || busy) && n < 1000) begin
            if (tb_rnd[k]) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
         out_ready = 1'b1;
         contend = 1'b0;
         repeat (3) tick();
         compared += 5;
         if (n >= 1000) begin mismatched++; $display("FAIL burst%0d_timeout: got %0d words, required %0d", k, got.size(), tb_len[k]); end
         if (acc_addr.size() != int'(tb_len[k])) begin
            mismatched++; $display("FAIL burst%0d_reads: got %0d, required %0d", k, acc_addr.size(), tb_len[k]);
         end
         if (got.size() != int'(tb_len[k])) begin
            mismatched++; $display("FAIL burst%0d_words: got %0d, required %0d", k, got.size(), tb_len[k]);
         end
         if (done_cnt != 1) begin mismatched++; $display("FAIL burst%0d_done: got %0d pulses, required 1", k, done_cnt); end
         if (first_valid_cyc - (start_cyc + 1) < 3) begin
            mismatched++; $display("FAIL burst%0d_latency: got %0d, required >=3", k, first_valid_cyc - (start_cyc + 1));
         end
         for (int i = 0; i < int'(tb_len[k]); i++) begin
            ea = tb_base[k] + AW'(i);
            if (i < acc_addr.size()) begin
               compared++;
               if (acc_addr[i] !== ea) begin mismatched++; $display("FAIL burst%0d_addr[%0d]: got %h, required %h", k, i, acc_addr[i], ea); end
            end
            if (i < got.size()) begin
               compared++;
               if (got[i] !== sram[ea]) begin mismatched++; $display("FAIL burst%0d_data[%0d]: got %h, required %h", k, i, got[i], sram[ea]); end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [AW-1:0] b, ea;
      b = AW'($urandom);
      acc_addr.delete(); got.delete(); done_cnt = 0;
      out_ready = 1'b0;
      pulse_start(b, 12'd8);
      n = 0;
      while (fifo_level != LW'(DEPTH) && n < 200) begin tick(); n++; end
      repeat (10) tick();
      compared += 4;
      if (acc_addr.size() != DEPTH) begin mismatched++; $display("FAIL bp_reads: got %0d, required %0d", acc_addr.size(), DEPTH); end
      if (fifo_level !== LW'(DEPTH)) begin mismatched++; $display("FAIL bp_level: got %0d, required %0d", fifo_level, DEPTH); end
      if (read_strobe !== 1'b0) begin mismatched++; $display("FAIL bp_strobe: got %b, required 0", read_strobe); end
      if (busy !== 1'b1) begin mismatched++; $display("FAIL bp_busy: got %b, required 1", busy); end
      out_ready = 1'b1;
      n = 0;
      while ((got.size() < 8 || busy) && n < 500) begin tick(); n++; end
      repeat (3) tick();
      compared += 2;
      if (got.size() != 8) begin mismatched++; $display("FAIL bp_words: got %0d, required 8", got.size()); end
      if (done_cnt != 1) begin mismatched++; $display("FAIL bp_done: got %0d, required 1", done_cnt); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         ea = b + AW'(i);
         compared++;
         if (got[i] !== sram[ea]) begin mismatched++; $display("FAIL bp_data[%0d]: got %h, required %h", i, got[i], sram[ea]); end
      end
   endtask

   task automatic test_reset_midburst();
      int n;
      acc_addr.delete(); got.delete();
      out_ready = 1'b0;
      pulse_start(AW'($urandom), 12'd6);
      n = 0;
      while (!(fifo_level == LW'(2) && read_strobe) && n < 200) begin tick(); n++; end
      compared++;
      if (n >= 200) begin mismatched++; $display("FAIL rstmid_reach: got level %0d, required 2 with strobe", fifo_level); end
      done_cnt = 0;
      rst = 1'b1;
      tick();
      compared += 6;
      if (busy !== 1'b0)        begin mismatched++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
      if (done !== 1'b0)        begin mismatched++; $display("FAIL rstmid_done: got %b, required 0", done); end
      if (read_strobe !== 1'b0) begin mismatched++; $display("FAIL rstmid_strobe: got %b, required 0", read_strobe); end
      if (read_address !== '0)  begin mismatched++; $display("FAIL rstmid_addr: got %h, required 0", read_address); end
      if (out_valid !== 1'b0)   begin mismatched++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
      if (fifo_level !== '0)    begin mismatched++; $display("FAIL rstmid_level: got %0d, required 0", fifo_level); end
      rst = 1'b0;
      repeat (5) tick();
      compared += 2;
      if (fifo_level !== '0) begin mismatched++; $display("FAIL rstmid_stale: got level %0d, required 0", fifo_level); end
      if (done_cnt != 0) begin mismatched++; $display("FAIL rstmid_nodone: got %0d, required 0", done_cnt); end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_zero_and_busy_start();
      int n;
      acc_addr.delete(); got.delete(); done_cnt = 0; busy_seen = 0;
      pulse_start(12'h123, 12'd0);
      repeat (4) tick();
      compared += 3;
      if (acc_addr.size() != 0) begin mismatched++; $display("FAIL zero_reads: got %0d, required 0", acc_addr.size()); end
      if (done_cnt != 1) begin mismatched++; $display("FAIL zero_done: got %0d, required 1", done_cnt); end
      if (busy_seen != 0) begin mismatched++; $display("FAIL zero_busy: got %0d busy cycles, required 0", busy_seen); end
      acc_addr.delete(); got.delete(); done_cnt = 0;
      pulse_start(12'h100, 12'd3);
      pulse_start(12'h200, 12'd5);
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      repeat (3) tick();
      compared += 2;
      if (acc_addr.size() != 3) begin mismatched++; $display("FAIL busystart_reads: got %0d, required 3", acc_addr.size()); end
      if (done_cnt != 1) begin mismatched++; $display("FAIL busystart_done: got %0d, required 1", done_cnt); end
      for (int i = 0; i < acc_addr.size() && i < 3; i++) begin
         compared++;
         if (acc_addr[i] !== 12'h100 + AW'(i)) begin
            mismatched++; $display("FAIL busystart_addr[%0d]: got %h, required %h", i, acc_addr[i], 12'h100 + AW'(i));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) sram[i] = DW'($urandom);
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      base_address = '0; length = '0;
      test_reset();
      test_bursts();
      test_backpressure();
      test_reset_midburst();
      test_zero_and_busy_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
